// File: rtl/adex_pkg.sv
// Shared defaults, sweep FSM encoding and arithmetic helpers for the AdEx neuron array.
package adex_pkg;

  localparam int N_NEURONS_DEF  = 8;
  localparam int W_DEF          = 8;
  localparam int V_REST_DEF     = 50;
  localparam int V_RESET_DEF    = 40;
  localparam int V_T_DEF        = 150;
  localparam int V_TH_DEF       = 200;
  localparam int TAU_SHIFT_DEF  = 3;
  localparam int TAUW_SHIFT_DEF = 4;
  localparam int B_INC_DEF      = 16;
  localparam int T_REF_DEF      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Exponential upswing above rheobase, indexed by the top nibble of (v - V_T).
  function automatic logic [7:0] exp_lut(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'd1;
      4'd1:    val = 8'd2;
      4'd2:    val = 8'd3;
      4'd3:    val = 8'd5;
      4'd4:    val = 8'd8;
      4'd5:    val = 8'd12;
      4'd6:    val = 8'd18;
      4'd7:    val = 8'd27;
      4'd8:    val = 8'd40;
      4'd9:    val = 8'd60;
      4'd10:   val = 8'd90;
      4'd11:   val = 8'd135;
      4'd12:   val = 8'd200;
      default: val = 8'd255;
    endcase
    return val;
  endfunction

  function automatic int clamp_int(input int x, input int hi);
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int sat_int(input int x, input int hi);
    return (x > hi) ? hi : x;
  endfunction

endpackage

// File: rtl/adex_update.sv
// Combinational AdEx update for one neuron: refractory hold, spike reset, or leak/exp/drive/adaptation.
module adex_update
  import adex_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int V_REST     = V_REST_DEF,
  parameter int V_RESET    = V_RESET_DEF,
  parameter int V_T        = V_T_DEF,
  parameter int V_TH       = V_TH_DEF,
  parameter int TAU_SHIFT  = TAU_SHIFT_DEF,
  parameter int TAUW_SHIFT = TAUW_SHIFT_DEF,
  parameter int B_INC      = B_INC_DEF,
  parameter int T_REF      = T_REF_DEF,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  v_i,
  input  logic [W-1:0]  w_i,
  input  logic [W-1:0]  cur_i,
  input  logic [RW-1:0] ref_i,
  output logic [W-1:0]  v_o,
  output logic [W-1:0]  w_o,
  output logic [RW-1:0] ref_o,
  output logic          fire_o
);

  localparam int SW   = W + 3;
  localparam int MAXV = (1 << W) - 1;
  localparam logic [W-1:0]         V_T_W     = W'(V_T);
  localparam logic [W-1:0]         V_TH_W    = W'(V_TH);
  localparam logic [W-1:0]         V_RESET_W = W'(V_RESET);
  localparam logic signed [SW-1:0] V_REST_S  = SW'(V_REST);
  localparam logic [RW-1:0]        T_REF_R   = RW'(T_REF);

  logic signed [SW-1:0] v_s, w_s, cur_s, exp_s, diff_s, leak_s, sum_s;
  logic [W-1:0] v_norm, w_dec, w_inc;

  assign v_s    = $signed({3'b000, v_i});
  assign w_s    = $signed({3'b000, w_i});
  assign cur_s  = $signed({3'b000, cur_i});
  assign exp_s  = (v_i >= V_T_W)
                ? $signed({{(SW-8){1'b0}}, exp_lut(4'((v_i - V_T_W) >> (W - 4)))})
                : '0;
  // Arithmetic shift keeps the leak signed so a sub-rest potential is pulled back up.
  assign diff_s = v_s - V_REST_S;
  assign leak_s = diff_s >>> TAU_SHIFT;
  assign sum_s  = v_s - leak_s + exp_s + cur_s - w_s;
  assign v_norm = W'(clamp_int(int'(sum_s), MAXV));
  assign w_dec  = w_i - (w_i >> TAUW_SHIFT);
  assign w_inc  = W'(sat_int(int'(w_i) + B_INC, MAXV));

  always_comb begin
    v_o    = v_norm;
    w_o    = w_dec;
    ref_o  = ref_i;
    fire_o = 1'b0;
    if (ref_i != '0) begin
      ref_o = ref_i - RW'(1);
      v_o   = V_RESET_W;
    end else if (v_i >= V_TH_W) begin
      fire_o = 1'b1;
      v_o    = V_RESET_W;
      w_o    = w_inc;
      ref_o  = T_REF_R;
    end
  end

endmodule

// File: rtl/adex_neuron_array.sv
// Time-multiplexed AdEx neuron array: one READ/UPDATE pair per neuron per step, spikes as indexed events.
module adex_neuron_array
  import adex_pkg::*;
#(
  parameter int N_NEURONS  = N_NEURONS_DEF,
  parameter int W          = W_DEF,
  parameter int V_REST     = V_REST_DEF,
  parameter int V_RESET    = V_RESET_DEF,
  parameter int V_T        = V_T_DEF,
  parameter int V_TH       = V_TH_DEF,
  parameter int TAU_SHIFT  = TAU_SHIFT_DEF,
  parameter int TAUW_SHIFT = TAUW_SHIFT_DEF,
  parameter int B_INC      = B_INC_DEF,
  parameter int T_REF      = T_REF_DEF,
  localparam int AW        = $clog2(N_NEURONS),
  localparam int RW        = (T_REF < 1) ? 1 : $clog2(T_REF + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          cur_we,
  input  logic [AW-1:0] cur_addr,
  input  logic [W-1:0]  cur_data,
  output logic          spike_valid,
  output logic [AW-1:0] spike_idx,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [W-1:0]  v_q   [N_NEURONS];
  logic [W-1:0]  w_q   [N_NEURONS];
  logic [W-1:0]  cur_q [N_NEURONS];
  logic [RW-1:0] refr_q[N_NEURONS];

  logic [W-1:0]  v_rd_q, w_rd_q, cur_rd_q;
  logic [RW-1:0] refr_rd_q;
  logic [W-1:0]  v_upd, w_upd;
  logic [RW-1:0] refr_upd;
  logic          fire;

  logic [N_NEURONS-1:0] upd_sel, wr_sel;
  logic          spike_valid_q, done_q, overrun_q;
  logic [AW-1:0] spike_idx_q;

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_sel
    assign upd_sel[gi] = (state_q == UPDATE) && (idx_q == AW'(gi));
    assign wr_sel[gi]  = cur_we && (cur_addr == AW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (step) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ:   state_d = UPDATE;
      UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        v_q[n]    <= W'(V_REST);
        w_q[n]    <= '0;
        refr_q[n] <= '0;
        cur_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (upd_sel[n]) begin
          v_q[n]    <= v_upd;
          w_q[n]    <= w_upd;
          refr_q[n] <= refr_upd;
        end
        if (wr_sel[n]) cur_q[n] <= cur_data;
      end
    end
  end

  // A current write landing in the READ cycle of the same neuron is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_rd_q    <= '0;
      w_rd_q    <= '0;
      refr_rd_q <= '0;
      cur_rd_q  <= '0;
    end else if (state_q == READ) begin
      v_rd_q    <= v_q[idx_q];
      w_rd_q    <= w_q[idx_q];
      refr_rd_q <= refr_q[idx_q];
      cur_rd_q  <= (cur_we && (cur_addr == idx_q)) ? cur_data : cur_q[idx_q];
    end
  end

  adex_update #(
    .W(W), .V_REST(V_REST), .V_RESET(V_RESET), .V_T(V_T), .V_TH(V_TH),
    .TAU_SHIFT(TAU_SHIFT), .TAUW_SHIFT(TAUW_SHIFT), .B_INC(B_INC),
    .T_REF(T_REF), .RW(RW)
  ) u_update (
    .v_i   (v_rd_q),
    .w_i   (w_rd_q),
    .cur_i (cur_rd_q),
    .ref_i (refr_rd_q),
    .v_o   (v_upd),
    .w_o   (w_upd),
    .ref_o (refr_upd),
    .fire_o(fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      spike_valid_q <= (state_q == UPDATE) && fire;
      if ((state_q == UPDATE) && fire) spike_idx_q <= idx_q;
      done_q <= (state_q == UPDATE) && (idx_q == LAST_IDX);
      if (step && busy) overrun_q <= 1'b1;
    end
  end

  assign busy        = (state_q != IDLE);
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adex_neuron_array.sv
// Directed bench for adex_neuron_array: sweep timing, spiking, adaptation, saturation, overrun and reset.
module tb_adex_neuron_array;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          step;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [W-1:0]  cur_data;
  logic          spike_valid;
  logic [AW-1:0] spike_idx;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adex_neuron_array #(.N_NEURONS(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .cur_we     (cur_we),
    .cur_addr   (cur_addr),
    .cur_data   (cur_data),
    .spike_valid(spike_valid),
    .spike_idx  (spike_idx),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    step     = 1'b0;
    cur_we   = 1'b0;
    cur_addr = '0;
    cur_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_cur(input logic [AW-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    cur_we   = 1'b1;
    cur_addr = addr;
    cur_data = data;
    @(negedge clk);
    cur_we = 1'b0;
  endtask

  // One sweep; mid_cyc > 0 re-asserts step for one cycle while the sweep is running.
  task automatic run_step(input string tag, input logic [N-1:0] exp_mask, input int mid_cyc,
                          output bit last_coinc);
    logic [N-1:0] mask;
    int done_cnt, done_at;
    bit idx_ok, busy_ok;
    mask = '0; done_cnt = 0; done_at = -1; idx_ok = 1'b1; busy_ok = 1'b1; last_coinc = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 1; k <= 2*N+1; k++) begin
      @(posedge clk);
      #1;
      step = (k == mid_cyc);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (spike_valid === 1'b1) begin
        mask[spike_idx] = 1'b1;
        if (k != 2*int'(spike_idx) + 2) idx_ok = 1'b0;
        if (done === 1'b1) last_coinc = 1'b1;
      end
      if (busy !== (k <= 2*N)) busy_ok = 1'b0;
    end
    step = 1'b0;
    $display("step %s: spikes=%b done_at=%0d", tag, mask, done_at);
    check({tag, " done cycle"}, done_at, 2*N);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " spike mask"}, 32'(mask), 32'(exp_mask));
    check({tag, " spike slot"}, 32'(idx_ok), 1);
    check({tag, " busy window"}, 32'(busy_ok), 1);
  endtask

  initial begin
    bit lc;
    do_reset();
    check("rst spike_valid", 32'(spike_valid), 0);
    check("rst spike_idx", 32'(spike_idx), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst v0", 32'(dut.v_q[0]), 50);

    // Quiescent sweep.
    run_step("t1", '0, 0, lc);
    check("t1 v5", 32'(dut.v_q[5]), 50);
    check("t1 overrun", 32'(overrun), 0);

    // Single driven neuron, then adaptation over several spikes.
    write_cur(3'd3, 8'd60);
    for (int s = 1; s <= 21; s++) begin
      run_step($sformatf("t4 s%0d", s), (s == 4 || s == 12 || s == 21) ? 8'h08 : 8'h00, 0, lc);
      case (s)
        1: check("t2 v3 s1", 32'(dut.v_q[3]), 110);
        2: check("t2 v3 s2", 32'(dut.v_q[3]), 163);
        3: check("t2 v3 s3", 32'(dut.v_q[3]), 210);
        4: begin
          check("t2 v3 s4", 32'(dut.v_q[3]), 40);
          check("t2 w3 s4", 32'(dut.w_q[3]), 16);
          check("t2 ref3 s4", 32'(dut.refr_q[3]), 2);
        end
        5: begin
          check("t2 v3 s5", 32'(dut.v_q[3]), 40);
          check("t2 ref3 s5", 32'(dut.refr_q[3]), 1);
          check("t2 w3 s5", 32'(dut.w_q[3]), 15);
        end
        6: begin
          check("t2 v3 s6", 32'(dut.v_q[3]), 40);
          check("t2 ref3 s6", 32'(dut.refr_q[3]), 0);
        end
        11: check("t4 v3 s11", 32'(dut.v_q[3]), 226);
        12: check("t4 w3 s12", 32'(dut.w_q[3]), 31);
        20: begin
          check("t4 v3 s20", 32'(dut.v_q[3]), 200);
          check("t4 w3 s20", 32'(dut.w_q[3]), 23);
        end
        21: begin
          check("t4 w3 s21", 32'(dut.w_q[3]), 39);
          check("t4 v2 s21", 32'(dut.v_q[2]), 50);
        end
        default: ;
      endcase
    end

    // Drive removed: w decays, v clamps at 0.
    write_cur(3'd3, 8'd0);
    for (int s = 22; s <= 25; s++) begin
      run_step($sformatf("t4 s%0d", s), '0, 0, lc);
      case (s)
        22: check("t4 w3 s22", 32'(dut.w_q[3]), 37);
        23: check("t4 w3 s23", 32'(dut.w_q[3]), 35);
        24: check("t4 v3 s24", 32'(dut.v_q[3]), 7);
        25: begin
          check("t4 v3 s25 clamp0", 32'(dut.v_q[3]), 0);
          check("t4 w3 s25", 32'(dut.w_q[3]), 31);
        end
        default: ;
      endcase
    end
    for (int s = 26; s <= 55; s++) run_step($sformatf("t4 s%0d", s), '0, 0, lc);
    check("t4 w3 settled", 32'(dut.w_q[3]), 15);
    check("t4 v3 settled", 32'(dut.v_q[3]), 0);

    // Step re-asserted mid-sweep.
    run_step("t5 mid", '0, 5, lc);
    check("t5 overrun set", 32'(overrun), 1);
    run_step("t5 next", '0, 0, lc);
    check("t5 overrun sticky", 32'(overrun), 1);

    // Reset during UPDATE of neuron 2.
    write_cur(3'd3, 8'd60);
    run_step("t6 pre", '0, 0, lc);
    check("t6 v3 pre", 32'(dut.v_q[3]), 52);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6 busy before rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("t6 rst spike_valid", 32'(spike_valid), 0);
    check("t6 rst done", 32'(done), 0);
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst overrun", 32'(overrun), 0);
    check("t6 rst v3", 32'(dut.v_q[3]), 50);
    check("t6 rst w3", 32'(dut.w_q[3]), 0);
    check("t6 rst cur3", 32'(dut.cur_q[3]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_step("t6 post", '0, 0, lc);
    check("t6 post v3", 32'(dut.v_q[3]), 50);
    check("t6 post overrun", 32'(overrun), 0);

    // Maximum drive on both ends of the array.
    write_cur(3'd0, 8'd255);
    write_cur(3'd7, 8'd255);
    run_step("t3 s1", '0, 0, lc);
    check("t3 v0 sat", 32'(dut.v_q[0]), 255);
    check("t3 v7 sat", 32'(dut.v_q[7]), 255);
    check("t3 v4", 32'(dut.v_q[4]), 50);
    run_step("t3 s2", 8'h81, 0, lc);
    check("t3 last spike with done", 32'(lc), 1);
    check("t3 v0 reset", 32'(dut.v_q[0]), 40);
    check("t3 w7 inc", 32'(dut.w_q[7]), 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
